// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing constants and colour constants for
// the VGA timing generator and its drawing clients.
package vga_pkg;

    typedef logic [11:0] rgb_t;
    typedef logic [10:0] coord_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam rgb_t COLOR_BLACK = 12'h000;
    localparam rgb_t COLOR_WHITE = 12'hFFF;

    function automatic logic in_range(input coord_t c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_color_bars.sv
// Eight vertical colour bars across the active width, white on the left down
// to black on the right; the bar index comes from a compare chain, no divider.
module color_bars
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic [10:0] pix_x,
    output logic [11:0] bar_rgb
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [6:0] past_edge;
    logic [2:0] bar_k;

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_cmp
            assign past_edge[gi] = (pix_x >= coord_t'((gi + 1) * BAR_W));
        end
    endgenerate

    // The comparisons form a thermometer code; its population is the bar index.
    always_comb begin
        bar_k = 3'd0;
        for (int i = 0; i < 7; i++) begin
            bar_k = bar_k + {2'b00, past_edge[i]};
        end
    end

    assign bar_rgb = {{4{~bar_k[2]}}, {4{~bar_k[1]}}, {4{~bar_k[0]}}};

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel divider, h/v counters, blanked and registered
// rgb/hsync/vsync outputs and a vblank-entry strobe. Optional colour-bar
// source is enabled with `define VGA_TEST_PATTERN_EN.
module vga_sync
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
    input  logic        test_mode,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        video_on,
    output logic        pix_tick,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [11:0] rgb_out,
    output logic        vblank_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    coord_t           h_cnt_q, h_cnt_d;
    coord_t           v_cnt_q, v_cnt_d;
    rgb_t             rgb_out_q, rgb_out_d;
    logic             hsync_out_q, hsync_out_d;
    logic             vsync_out_q, vsync_out_d;
    logic             vblank_start_q, vblank_start_d;
    logic             h_last, v_last;
    rgb_t             src_rgb;

`ifdef VGA_TEST_PATTERN_EN
    rgb_t bar_rgb;

    color_bars #(.H_ACTIVE(H_ACTIVE)) u_color_bars (
        .pix_x   (h_cnt_q),
        .bar_rgb (bar_rgb)
    );

    assign src_rgb = test_mode ? bar_rgb : rgb_in;
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign src_rgb          = rgb_in;
`endif

    assign pix_tick = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign h_last   = (h_cnt_q == coord_t'(H_TOT - 1));
    assign v_last   = (v_cnt_q == coord_t'(V_TOT - 1));
    assign video_on = (h_cnt_q < coord_t'(H_ACTIVE)) && (v_cnt_q < coord_t'(V_ACTIVE));

    always_comb begin
        div_cnt_d      = div_cnt_q;
        h_cnt_d        = h_cnt_q;
        v_cnt_d        = v_cnt_q;
        rgb_out_d      = rgb_out_q;
        hsync_out_d    = hsync_out_q;
        vsync_out_d    = vsync_out_q;
        vblank_start_d = 1'b0;
        if (pix_tick) begin
            div_cnt_d = '0;
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? coord_t'(0) : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
            // Output stage samples the pixel being left, so it trails pix_x/pix_y by one period.
            rgb_out_d      = video_on ? src_rgb : COLOR_BLACK;
            hsync_out_d    = ~in_range(h_cnt_q, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC - 1);
            vsync_out_d    = ~in_range(v_cnt_q, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC - 1);
            vblank_start_d = h_last && (v_cnt_q == coord_t'(V_ACTIVE - 1));
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q      <= '0;
            h_cnt_q        <= '0;
            v_cnt_q        <= '0;
            rgb_out_q      <= COLOR_BLACK;
            hsync_out_q    <= 1'b1;
            vsync_out_q    <= 1'b1;
            vblank_start_q <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            rgb_out_q      <= rgb_out_d;
            hsync_out_q    <= hsync_out_d;
            vsync_out_q    <= vsync_out_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    assign pix_x        = h_cnt_q;
    assign pix_y        = v_cnt_q;
    assign rgb_out      = rgb_out_q;
    assign hsync_out    = hsync_out_q;
    assign vsync_out    = vsync_out_q;
    assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: full 800-pixel lines with a shortened 15-line frame so a
// whole frame fits; expected outputs are queued per pixel tick and popped one tick later.
module tb_vga_sync;

    localparam int CD = 2;
    localparam int HA = 640, HF = 16, HS = 96, HB = 48, HT = 800;
    localparam int VA = 8, VF = 2, VS = 2, VB = 3, VT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] rgb_in;
    logic        test_mode;
    logic [10:0] pix_x, pix_y;
    logic        video_on, pix_tick, hsync_out, vsync_out, vblank_start;
    logic [11:0] rgb_out;

    vga_sync #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .rgb_in(rgb_in), .test_mode(test_mode),
        .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on), .pix_tick(pix_tick),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .rgb_out(rgb_out),
        .vblank_start(vblank_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int          e;              // edges since reset release, -1 before the first
    logic [13:0] sb_q[$];        // {rgb, hsync, vsync}
    logic [13:0] last_out;
    bit          rand_mode;
    logic        prev_hs;
    int          hs_low, vs_low, vid_clks, vb_pulses, abc_clks, hs_fall1, hs_fall2;

    function automatic int pix_idx(input int ed);
        return ((ed + 1) / CD) % (HT * VT);
    endfunction

    function automatic logic [11:0] exp_rgb(input int h, input int v, input logic [11:0] c);
        logic [2:0] k;
        if (!(h < HA && v < VA)) return 12'h000;
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) begin
            k = 3'(h / (HA / 8));
            return {{4{~k[2]}}, {4{~k[1]}}, {4{~k[0]}}};
        end
`endif
        return c;
    endfunction

    task automatic model_reset();
        e        = -1;
        sb_q.delete();
        last_out = {12'h000, 1'b1, 1'b1};
        prev_hs  = 1'b1;
    endtask

    task automatic clear_meas();
        hs_low = 0; vs_low = 0; vid_clks = 0; vb_pulses = 0; abc_clks = 0;
        hs_fall1 = -1; hs_fall2 = -1;
    endtask

    task automatic step();
        int ne, p, h, v, pn, hn, vn;
        logic exp_vb, exp_vo, hs_e, vs_e;
        logic [37:0] act_all, exp_all;
        ne = e + 1;
        p  = pix_idx(e);
        h  = p % HT;
        v  = p / HT;
        if ((ne % CD) == CD - 1) begin
            rgb_in = rand_mode ? 12'($urandom) : 12'hABC;
            hs_e   = !(h >= HA + HF && h <= HA + HF + HS - 1);
            vs_e   = !(v >= VA + VF && v <= VA + VF + VS - 1);
            sb_q.push_back({exp_rgb(h, v, rgb_in), hs_e, vs_e});
        end else begin
            rgb_in = 12'($urandom);   // must never be sampled
        end
        @(posedge clk);
        #1;
        e      = ne;
        exp_vb = 1'b0;
        if ((e % CD) == CD - 1) begin
            if (sb_q.size() != 0) last_out = sb_q.pop_front();
            exp_vb = (h == HT - 1) && (v == VA - 1);
        end
        pn      = pix_idx(e);
        hn      = pn % HT;
        vn      = pn / HT;
        exp_vo  = (hn < HA) && (vn < VA);
        act_all = {pix_x, pix_y, video_on, rgb_out, hsync_out, vsync_out, vblank_start};
        exp_all = {11'(hn), 11'(vn), exp_vo, last_out, exp_vb};
        n_checks++;
        if (act_all !== exp_all) begin
            n_fail++;
            $display("FAIL edge e=%0d x/y/von/rgb/hs/vs/vb got %0d/%0d/%b/%h/%b/%b/%b want %0d/%0d/%b/%h/%b/%b/%b",
                     e, pix_x, pix_y, video_on, rgb_out, hsync_out, vsync_out, vblank_start,
                     hn, vn, exp_vo, last_out[13:2], last_out[1], last_out[0], exp_vb);
        end
        if (!hsync_out) hs_low++;
        if (!vsync_out) vs_low++;
        if (video_on) vid_clks++;
        if (vblank_start) vb_pulses++;
        if (rgb_out == 12'hABC) abc_clks++;
        if (prev_hs && !hsync_out) begin
            if (hs_fall1 < 0) hs_fall1 = e;
            else if (hs_fall2 < 0) hs_fall2 = e;
        end
        prev_hs = hsync_out;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rgb_in    = 12'hABC;
        test_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clear_meas();
        n_checks++; if (pix_x !== 11'd0) begin n_fail++; $display("FAIL reset_pix_x got %0d want 0", pix_x); end
        n_checks++; if (pix_y !== 11'd0) begin n_fail++; $display("FAIL reset_pix_y got %0d want 0", pix_y); end
        n_checks++; if (video_on !== 1'b1) begin n_fail++; $display("FAIL reset_video_on got %b want 1", video_on); end
        n_checks++; if (hsync_out !== 1'b1) begin n_fail++; $display("FAIL reset_hsync got %b want 1", hsync_out); end
        n_checks++; if (vsync_out !== 1'b1) begin n_fail++; $display("FAIL reset_vsync got %b want 1", vsync_out); end
        n_checks++; if (rgb_out !== 12'h000) begin n_fail++; $display("FAIL reset_rgb got %h want 000", rgb_out); end
        n_checks++; if (vblank_start !== 1'b0) begin n_fail++; $display("FAIL reset_vblank got %b want 0", vblank_start); end
    endtask

    // One complete frame with rgb_in = ABC at every tick: timing and blanking totals.
    task automatic test_frame();
        rand_mode = 1'b0;
        repeat (HT * VT * CD) step();
        n_checks++; if (hs_fall1 !== 1313) begin n_fail++; $display("FAIL first_hsync_fall got %0d want 1313", hs_fall1); end
        n_checks++; if (hs_fall2 - hs_fall1 !== 1600) begin n_fail++; $display("FAIL hsync_period got %0d want 1600", hs_fall2 - hs_fall1); end
        n_checks++; if (hs_low !== VT * HS * CD) begin n_fail++; $display("FAIL hsync_low_clks got %0d want %0d", hs_low, VT * HS * CD); end
        n_checks++; if (vs_low !== VS * HT * CD) begin n_fail++; $display("FAIL vsync_low_clks got %0d want %0d", vs_low, VS * HT * CD); end
        n_checks++; if (vid_clks !== VA * HA * CD) begin n_fail++; $display("FAIL video_on_clks got %0d want %0d", vid_clks, VA * HA * CD); end
        n_checks++; if (abc_clks !== VA * HA * CD) begin n_fail++; $display("FAIL rgb_abc_clks got %0d want %0d", abc_clks, VA * HA * CD); end
        n_checks++; if (vb_pulses !== 1) begin n_fail++; $display("FAIL vblank_pulses got %0d want 1", vb_pulses); end
    endtask

    task automatic test_back_to_back();
        rand_mode = 1'b1;
        clear_meas();
        repeat (6000) step();
    endtask

    task automatic test_midframe_reset();
        int budget, p;
        rand_mode = 1'b1;
        budget    = 0;
        p         = pix_idx(e);
        while (!((p % HT) == 300 && (p / HT) == 5) && budget < 30000) begin
            step();
            budget++;
            p = pix_idx(e);
        end
        n_checks++;
        if (budget >= 30000) begin n_fail++; $display("FAIL midframe_reach got budget %0d want < 30000", budget); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({pix_x, pix_y, hsync_out, vsync_out, rgb_out, vblank_start} !== {22'd0, 1'b1, 1'b1, 12'h000, 1'b0}) begin
            n_fail++;
            $display("FAIL midframe_reset x/y/hs/vs/rgb/vb got %0d/%0d/%b/%b/%h/%b want 0/0/1/1/000/0",
                     pix_x, pix_y, hsync_out, vsync_out, rgb_out, vblank_start);
        end
        rst = 1'b0;
        model_reset();
        clear_meas();
        repeat (HT * CD) step();
        n_checks++; if (hs_fall1 !== 1313) begin n_fail++; $display("FAIL post_reset_hsync_fall got %0d want 1313", hs_fall1); end
    endtask

    task automatic test_test_mode();
        rand_mode = 1'b1;
        test_mode = 1'b1;
        repeat (2 * HT * CD) step();
        test_mode = 1'b0;
        repeat (HT * CD) step();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_midframe_reset();
        test_test_mode();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
